// File: rtl/i2c_slave_regs.sv
// I2C target with an 8-bit register file, sampled entirely in the system clock domain.
// Supports pointer write, data write, read, repeated START and pointer auto-increment.
module i2c_slave_regs #(
   parameter logic [6:0]  I2C_ADDR    = 7'h1C,
   parameter int unsigned NUM_REGS    = 8,
   parameter int unsigned SYNC_STAGES = 2,
   localparam int unsigned AW         = $clog2(NUM_REGS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  scl_i,
   input  logic                  sda_i,
   output logic                  sda_oe,
   output logic [NUM_REGS*8-1:0] reg_out,
   output logic                  wr_strobe,
   output logic [AW-1:0]         wr_addr,
   output logic                  busy
);

   typedef enum logic [3:0] {
      StIdle, StAddr, StAckA, StPtr, StAckP, StWdata, StAckW, StRdata, StMack, StIgnore
   } state_t;

   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic                   scl_s, sda_s, scl_prev, sda_prev;
   logic                   scl_rise, scl_fall, start_c, stop_c;

   state_t                 state_q, state_d;
   logic [3:0]             bitcnt_q, bitcnt_d;
   logic [7:0]             shreg_q, shreg_d;
   logic                   rw_q, rw_d;
   logic [AW-1:0]          ptr_q, ptr_d, ptr_inc;
   logic [NUM_REGS*8-1:0]  regs_q, regs_d;
   logic                   sda_oe_q, sda_oe_d;
   logic                   wr_strobe_q, wr_strobe_d;
   logic [AW-1:0]          wr_addr_q, wr_addr_d;
   logic                   busy_q, busy_d;
   logic [7:0]             rx_byte, cur_reg, nxt_reg;

   // Synchronisers idle high so reset release never fakes a START/STOP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_prev <= 1'b1;
         sda_prev <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
         scl_prev <= scl_s;
         sda_prev <= sda_s;
      end
   end

   assign scl_s    = scl_sync[SYNC_STAGES-1];
   assign sda_s    = sda_sync[SYNC_STAGES-1];
   assign scl_rise = scl_s & ~scl_prev;
   assign scl_fall = ~scl_s & scl_prev;
   assign start_c  = scl_s & sda_prev & ~sda_s;
   assign stop_c   = scl_s & ~sda_prev & sda_s;

   assign ptr_inc = ptr_q + 1'b1;
   assign rx_byte = {shreg_q[6:0], sda_s};
   assign cur_reg = regs_q[{ptr_q, 3'b000} +: 8];
   assign nxt_reg = regs_q[{ptr_inc, 3'b000} +: 8];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         bitcnt_q    <= '0;
         shreg_q     <= '0;
         rw_q        <= 1'b0;
         ptr_q       <= '0;
         regs_q      <= '0;
         sda_oe_q    <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bitcnt_q    <= bitcnt_d;
         shreg_q     <= shreg_d;
         rw_q        <= rw_d;
         ptr_q       <= ptr_d;
         regs_q      <= regs_d;
         sda_oe_q    <= sda_oe_d;
         wr_strobe_q <= wr_strobe_d;
         wr_addr_q   <= wr_addr_d;
         busy_q      <= busy_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      bitcnt_d    = bitcnt_q;
      shreg_d     = shreg_q;
      rw_d        = rw_q;
      ptr_d       = ptr_q;
      regs_d      = regs_q;
      sda_oe_d    = sda_oe_q;
      wr_strobe_d = 1'b0;
      wr_addr_d   = wr_addr_q;
      busy_d      = busy_q;

      if (stop_c) begin
         state_d  = StIdle;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else if (start_c) begin
         state_d  = StAddr;
         bitcnt_d = '0;
         sda_oe_d = 1'b0;
         busy_d   = 1'b1;
      end else if (scl_rise) begin
         case (state_q)
            StAddr, StPtr, StWdata: begin
               if (bitcnt_q < 4'd8) begin
                  shreg_d  = rx_byte;
                  bitcnt_d = bitcnt_q + 4'd1;
                  // Commit only on the last bit so an aborted byte never lands.
                  if (state_q == StWdata && bitcnt_q == 4'd7) begin
                     regs_d[{ptr_q, 3'b000} +: 8] = rx_byte;
                     wr_strobe_d = 1'b1;
                     wr_addr_d   = ptr_q;
                     ptr_d       = ptr_inc;
                  end
               end
            end
            StMack: begin
               if (!sda_s) begin
                  ptr_d    = ptr_inc;
                  shreg_d  = nxt_reg;
                  bitcnt_d = '0;
                  state_d  = StRdata;
               end else begin
                  state_d = StIgnore;
               end
            end
            default: ;
         endcase
      end else if (scl_fall) begin
         case (state_q)
            StAddr: begin
               if (bitcnt_q == 4'd8) begin
                  if (shreg_q[7:1] == I2C_ADDR) begin
                     rw_d     = shreg_q[0];
                     sda_oe_d = 1'b1;
                     state_d  = StAckA;
                  end else begin
                     state_d = StIgnore;
                  end
               end
            end
            StAckA: begin
               if (rw_q) begin
                  // This edge ends the ACK slot, so the MSB goes out right away.
                  sda_oe_d = ~cur_reg[7];
                  shreg_d  = {cur_reg[6:0], 1'b0};
                  bitcnt_d = 4'd1;
                  state_d  = StRdata;
               end else begin
                  sda_oe_d = 1'b0;
                  bitcnt_d = '0;
                  state_d  = StPtr;
               end
            end
            StPtr: begin
               if (bitcnt_q == 4'd8) begin
                  if ({1'b0, shreg_q} < 9'(NUM_REGS)) begin
                     ptr_d    = shreg_q[AW-1:0];
                     sda_oe_d = 1'b1;
                     state_d  = StAckP;
                  end else begin
                     state_d = StIgnore;
                  end
               end
            end
            StAckP, StAckW: begin
               sda_oe_d = 1'b0;
               bitcnt_d = '0;
               state_d  = StWdata;
            end
            StWdata: begin
               if (bitcnt_q == 4'd8) begin
                  sda_oe_d = 1'b1;
                  state_d  = StAckW;
               end
            end
            StRdata: begin
               if (bitcnt_q == 4'd8) begin
                  sda_oe_d = 1'b0;
                  state_d  = StMack;
               end else begin
                  sda_oe_d = ~shreg_q[7];
                  shreg_d  = {shreg_q[6:0], 1'b0};
                  bitcnt_d = bitcnt_q + 4'd1;
               end
            end
            StIgnore: sda_oe_d = 1'b0;
            default: ;
         endcase
      end
   end

   assign sda_oe    = sda_oe_q;
   assign reg_out   = regs_q;
   assign wr_strobe = wr_strobe_q;
   assign wr_addr   = wr_addr_q;
   assign busy      = busy_q;

endmodule
